// File: rtl/alu_sequencer.sv
// Command FIFO feeding an external multi-cycle ALU.
// One operation in flight; results held until the consumer takes them.
module alu_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [31:0] alu_x,
    input  logic [31:0] alu_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_x,
    output logic [31:0] rsp_y,
    output logic [3:0]  rsp_opcode,
    output logic        rsp_err,
    output logic [15:0] ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    fifo_op_q [DEPTH];
    logic [3:0]    fifo_a_q  [DEPTH];
    logic [3:0]    fifo_b_q  [DEPTH];

    logic [3:0]    alu_op_q, alu_a_q, alu_b_q;
    logic [31:0]   rsp_x_q, rsp_y_q;
    logic [3:0]    rsp_op_q;
    logic          rsp_err_q;
    logic [15:0]   ops_q;

    logic          push, pop;
    logic          load_alu, cap_alu, cap_err, rsp_fire;
    logic [3:0]    head_op, head_a, head_b;

    function automatic logic is_legal(input logic [3:0] op);
        logic ok;
        case (op)
            4'h0, 4'h1, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign cmd_ready  = (count_q < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head_op    = fifo_op_q[rd_ptr_q];
    assign head_a     = fifo_a_q[rd_ptr_q];
    assign head_b     = fifo_b_q[rd_ptr_q];

    assign alu_opcode = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_opcode = rsp_op_q;
    assign rsp_err    = rsp_err_q;
    assign ops_done   = ops_q;

    // Sequencer next state: pop in IDLE, settle in ISSUE, hold in RESP.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pop      = 1'b0;
        load_alu = 1'b0;
        cap_alu  = 1'b0;
        cap_err  = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (is_legal(head_op)) begin
                        state_d  = S_ISSUE;
                        settle_d = '0;
                        load_alu = 1'b1;
                    end else begin
                        state_d = S_RESP;
                        cap_err = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d  = S_RESP;
                    settle_d = '0;
                    cap_alu  = 1'b1;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d  = S_IDLE;
                    rsp_fire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // FIFO pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q] <= cmd_opcode;
            fifo_a_q[wr_ptr_q]  <= cmd_a;
            fifo_b_q[wr_ptr_q]  <= cmd_b;
        end
    end

    // ALU drive registers, loaded only when a legal op is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
        end else if (load_alu) begin
            alu_op_q <= head_op;
            alu_a_q  <= head_a;
            alu_b_q  <= head_b;
        end
    end

    // Response capture from the ALU, or an error record for bad opcodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_x_q   <= '0;
            rsp_y_q   <= '0;
            rsp_op_q  <= '0;
            rsp_err_q <= 1'b0;
        end else if (cap_alu) begin
            rsp_x_q   <= alu_x;
            rsp_y_q   <= alu_y;
            rsp_op_q  <= alu_op_q;
            rsp_err_q <= 1'b0;
        end else if (cap_err) begin
            rsp_x_q   <= '0;
            rsp_y_q   <= '0;
            rsp_op_q  <= head_op;
            rsp_err_q <= 1'b1;
        end
    end

    // Saturating count of responses handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q <= '0;
        end else if (rsp_fire && ops_q != 16'hFFFF) begin
            ops_q <= ops_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed checks of alu_sequencer against a queue model.
// The bench also plays the external ALU.
module tb_alu_sequencer;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_opcode, cmd_a, cmd_b;
    logic [3:0]  alu_opcode, alu_a, alu_b;
    logic [31:0] alu_x, alu_y;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_x, rsp_y;
    logic [3:0]  rsp_opcode;
    logic        rsp_err;
    logic [15:0] ops_done;

    alu_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_x(alu_x), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_y(rsp_y),
        .rsp_opcode(rsp_opcode), .rsp_err(rsp_err),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op, a, b;
        logic [31:0] x, y;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_ops = 0;
    int   got_rsp = 0;
    logic [3:0] exp_alu_op = 4'h0, exp_alu_a = 4'h0, exp_alu_b = 4'h0;

    function automatic logic legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    endfunction

    function automatic logic [31:0] ref_x(input logic [3:0] op, a, b);
        logic [31:0] ea, eb;
        ea = {28'h0, a};
        eb = {28'h0, b};
        case (op)
            4'h0: return ea + eb;
            4'h1: return ea << b;
            4'h3: return ea & eb;
            4'h4: return ea | eb;
            4'h5: return ea >> b;
            4'h6: return (a > b) ? 32'd1 : 32'd0;
            4'h7: return ea ^ eb;
            4'h8: return ea - eb;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_y(input logic [3:0] op, a, b);
        if (op == 4'h0) return 32'h0;
        if (op == 4'h8) return (a < b) ? 32'd1 : 32'd0;
        return {16'hC0DE, 4'h0, op, a, b};
    endfunction

    // External ALU: combinational from the registered drives.
    always_comb begin
        alu_x = ref_x(alu_opcode, alu_a, alu_b);
        alu_y = ref_y(alu_opcode, alu_a, alu_b);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle from a falling edge to the next falling edge.
    task automatic step(input logic v, input logic [3:0] op, a, b,
                        input logic rr);
        rsp_t e;
        cmd_valid  = v;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        rsp_ready  = rr;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                check("rsp_x", rsp_x, exp_q[0].x);
                check("rsp_y", rsp_y, exp_q[0].y);
                check("rsp_err_op", 32'({rsp_err, rsp_opcode}),
                      32'({exp_q[0].err, exp_q[0].op}));
                if (rr) begin
                    e = exp_q.pop_front();
                    if (!e.err) begin
                        exp_alu_op = e.op;
                        exp_alu_a  = e.a;
                        exp_alu_b  = e.b;
                    end
                    model_ops++;
                    got_rsp++;
                end
            end
        end
        if (v && cmd_ready) begin
            e.op = op;
            e.a  = a;
            e.b  = b;
            e.err = !legal(op);
            e.x  = e.err ? 32'h0 : ref_x(op, a, b);
            e.y  = e.err ? 32'h0 : ref_y(op, a, b);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rx"}, rsp_x, 32'h0);
        check({tag, "_ry"}, rsp_y, 32'h0);
        check({tag, "_rop"}, 32'({rsp_err, rsp_opcode}), 32'h0);
        check({tag, "_alu"}, 32'({alu_opcode, alu_a, alu_b}), 32'h0);
        check({tag, "_ops"}, 32'(ops_done), 32'h0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        model_ops  = 0;
        exp_alu_op = 4'h0;
        exp_alu_a  = 4'h0;
        exp_alu_b  = 4'h0;
    endtask

    // Single operation from an idle, empty sequencer.
    task automatic one_op(input logic [3:0] op, a, b);
        int n;
        n = 0;
        step(1'b1, op, a, b, 1'b0);
        while (!rsp_valid && n < 20) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
            n++;
        end
        check("latency", 32'(n), legal(op) ? 32'(SETTLE + 1) : 32'd1);
        if (legal(op))
            check("alu_drive", 32'({alu_opcode, alu_a, alu_b}),
                  32'({op, a, b}));
        else
            check("alu_kept", 32'({alu_opcode, alu_a, alu_b}),
                  32'({exp_alu_op, exp_alu_a, exp_alu_b}));
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("ops_done", 32'(ops_done), 32'(model_ops));
    endtask

    logic [3:0] burst_op [5] = '{4'h0, 4'h8, 4'h1, 4'h7, 4'hC};

    task automatic fill_burst();
        for (int i = 0; i < 5; i++)
            step(1'b1, burst_op[i], 4'(i + 3), 4'(i + 1), 1'b0);
    endtask

    initial begin
        int start, n, sent, seen;
        logic v, rr;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 4'h0;
        cmd_a      = 4'h0;
        cmd_b      = 4'h0;
        rsp_ready  = 1'b0;
        #12;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD F+1, then an illegal opcode leaving the ALU drive alone.
        one_op(4'h0, 4'hF, 4'h1);
        check("add_x", rsp_x, 32'h10);
        one_op(4'hF, 4'h3, 4'h4);
        one_op(4'h8, 4'h2, 4'h9);
        one_op(4'h2, 4'h1, 4'h1);
        one_op(4'h1, 4'h5, 4'h3);

        // Response held for 10 cycles, counted once.
        start = model_ops;
        step(1'b1, 4'h6, 4'h9, 4'h2, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        check("hold_ops", 32'(ops_done), 32'(start));
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        check("hold_ops1", 32'(ops_done), 32'(start + 1));

        // Five commands against a stalled consumer, then drain.
        start = got_rsp;
        fill_burst();
        check("full_ready", 32'(cmd_ready), 32'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            n++;
        end
        check("drain_cnt", 32'(got_rsp - start), 32'd5);
        check("drain_ops", 32'(ops_done), 32'(model_ops));

        // Reset while an op is settling with three commands queued.
        fill_burst();
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("issue_op", 32'(alu_opcode), 32'(burst_op[1]));
        check("issue_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) seen++;
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        end
        check("post_rst_rsp", 32'(seen), 32'd0);
        check("post_rst_ops", 32'(ops_done), 32'd0);

        // Random traffic: 20 commands, random valid/ready.
        start = got_rsp;
        sent  = 0;
        n     = 0;
        while ((got_rsp - start) < 20 && n < 3000) begin
            v  = (sent < 20) && ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 3) != 0);
            if (v && cmd_ready) sent++;
            step(v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), rr);
            n++;
        end
        check("rand_cnt", 32'(got_rsp - start), 32'd20);
        check("rand_ops", 32'(ops_done), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set command FIFO entries (power of two, >=2).
REQ-002 Parameter SETTLE, default 1, SHALL set ALU settle cycles per operation (1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  SHALL flag a command offered.
REQ-006 cmd_ready  output  1  SHALL flag FIFO space available.
REQ-007 cmd_opcode  input  4  SHALL carry the operation code.
REQ-008 cmd_a, cmd_b  input  4 each  SHALL carry the operands.
REQ-009 alu_opcode, alu_a, alu_b  output  4 each  SHALL be registered drives to the external ALU.
REQ-010 alu_x, alu_y  input  32 each  SHALL be the ALU result low word and carry/high word.
REQ-011 rsp_valid  output  1  SHALL flag a result held.
REQ-012 rsp_ready  input  1  SHALL flag consumer acceptance.
REQ-013 rsp_x, rsp_y  output  32 each  SHALL carry the captured result.
REQ-014 rsp_opcode  output  4  SHALL echo the opcode of the result.
REQ-015 rsp_err  output  1  SHALL flag an illegal opcode.
REQ-016 ops_done  output  16  SHALL count completed responses, saturating at 16'hFFFF.

Function
REQ-017 Legal opcodes SHALL be 0000 ADD, 0001 SHL, 0011 AND, 0100 OR, 0101 SHR, 0110 GT, 0111 XOR, 1000 SUB; all others illegal.
REQ-018 Command SHALL be accepted on an edge with cmd_valid && cmd_ready and written to the FIFO tail that edge.
REQ-019 cmd_ready SHALL equal (count < DEPTH) from registered count only, with no combinational path from rsp_ready or the pop.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push when full SHALL be impossible; pop when empty SHALL never occur.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-022 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-023 IDLE: if FIFO non-empty, pop head at next edge; legal opcode -> ISSUE, illegal -> RESP; else stay IDLE.
REQ-024 On IDLE->ISSUE edge, alu_opcode/alu_a/alu_b SHALL load the popped command and hold until the next ISSUE entry.
REQ-025 ISSUE SHALL last exactly SETTLE cycles, counted by a settle counter cleared on entry.
REQ-026 On the final ISSUE edge, rsp_x<=alu_x, rsp_y<=alu_y, rsp_opcode<=alu_opcode, rsp_err<=0, enter RESP.
REQ-027 Illegal opcode path SHALL set rsp_x=rsp_y=0, rsp_err=1, rsp_opcode=popped code, leave alu_* unchanged.
REQ-028 RESP: rsp_valid=1; rsp_* SHALL stay stable until rsp_valid && rsp_ready edge, then go IDLE and increment ops_done.
REQ-029 rsp_valid SHALL be 1 only in RESP; legal-op latency from accepting edge to rsp_valid high SHALL be SETTLE+1 edges, illegal-op latency 1 edge, when FIFO empty and FSM IDLE.
REQ-030 Responses SHALL emerge in command acceptance order; at most one operation in flight.
REQ-031 Commands SHALL continue to be accepted during ISSUE and RESP while cmd_ready=1.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, FIFO empty, count 0, settle counter 0, cmd_ready 1 (after internal clear), rsp_valid 0, rsp_x/rsp_y/rsp_opcode/rsp_err 0, alu_* 0, ops_done 0.
REQ-033 Reset asserted mid-ISSUE or mid-RESP SHALL discard the in-flight and queued commands; no response for them ever appears.
REQ-034 Reset deassertion SHALL be synchronized by the integrating design; first command accepted on the first edge with rst_n high.

Verification
REQ-035 ADD a=4'hF b=4'h1, SETTLE=1, ALU model drives x=32'h10, y=0 -> rsp_valid high 2 edges after accept, rsp_x=32'h10, rsp_err=0, ops_done=1.
REQ-036 Opcode 4'b1111 -> rsp_valid after 1 edge, rsp_err=1, rsp_x=rsp_y=0, alu_* unchanged.
REQ-037 Push 5 commands with rsp_ready=0, DEPTH=4 -> cmd_ready low after queue fills (4 queued + 1 in RESP); release rsp_ready -> all 5 responses in order.
REQ-038 rsp_ready held low 10 cycles in RESP -> rsp_* stable all 10 cycles, ops_done increments once.
REQ-039 rst_n pulsed low during ISSUE with 3 queued -> all outputs reset values within same cycle, no later responses, ops_done=0.
REQ-040 Continuous traffic, 20 commands with random cmd_valid/rsp_ready -> pointer wrap exercised, responses match scoreboard, ops_done=20.
